lm_sm_sequencer: RTL
====================

Name: lm_sm_sequencer

Overview:
- Multi-cycle controller for Load-Multiple (LM) and Store-Multiple (SM) instructions in the 16-bit RISC pipeline.
- Accepts one LM/SM from register-read with its 8-bit register mask and base address.
- Stalls the front end, then issues one memory micro-op per set mask bit into the EX/MEM pipeline register (LM_addr / Data_B_SM path), with valid/ready backpressure from the memory stage.
- Signals completion so the front end resumes.

Parameters:
- ADDR_W, 16, width of base and generated addresses.
- NREG, 8, number of architectural registers (mask width).
- ADDR_STEP, 1, address increment per issued micro-op (word addressing).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  LM/SM instruction valid in register-read this cycle.
- opcode  in  4  instruction opcode; 4'b0110 = LM, 4'b0111 = SM.
- reg_mask  in  NREG  bit i set = transfer register Ri.
- base_addr  in  ADDR_W  first memory address (contents of RA).
- kill  in  1  synchronous flush from a later-stage branch/jump.
- mem_ready  in  1  memory stage accepts the current micro-op.
- stall  out  1  freeze IF/ID/RR pipeline registers.
- busy  out  1  sequence in progress.
- step_valid  out  1  micro-op valid.
- step_store  out  1  1 = SM micro-op, 0 = LM micro-op.
- step_reg  out  3  destination (LM) or source (SM) register index.
- step_addr  out  ADDR_W  memory address of the micro-op.
- done  out  1  one-cycle pulse when the sequence completes.

Behaviour:
- States: IDLE, ISSUE, DONE. Registers: remaining-mask, address, is_store.
- Reset (asynchronous assert, synchronous release): state = IDLE, remaining-mask = 0, address = 0, is_store = 0. All outputs are 0.
- Acceptance condition (accept): start=1 and opcode is LM or SM and kill=0.
- IDLE, on accept:
  - Latch reg_mask, base_addr, and is_store = (opcode==SM).
  - Next state is ISSUE if the mask is nonzero, else DONE.
  - stall is asserted combinationally in the accept cycle.
- IDLE, start with any other opcode: ignored.
- ISSUE:
  - step_valid = 1.
  - step_reg = index of the lowest set bit of remaining-mask (R0 first).
  - step_addr = address register; step_store = is_store.
  - Transfer occurs when step_valid and mem_ready are both 1. On transfer: clear that mask bit; address += ADDR_STEP, modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
  - If mem_ready=0, all step_* outputs are held stable. No combinational path from mem_ready to step_* outputs.
  - After the transfer of the last set bit, next state is DONE.
- DONE: done = 1 for exactly one cycle, stall = 0, then IDLE.
  - Latency: N set bits with mem_ready held at 1 gives N ISSUE cycles plus 1 DONE cycle after the accept edge.
  - Zero mask: the DONE cycle immediately follows accept; no micro-ops are issued.
- stall = accept OR (state==ISSUE). busy = (state != IDLE).
- kill, any state: next state is IDLE and remaining-mask is cleared. No done pulse. An in-flight step_valid drops on the next cycle; a transfer coinciding with kill still counts.
- kill and start in the same cycle: kill wins and nothing is accepted.
- start while busy: ignored.
- reset_n asserted mid-sequence: immediate return to IDLE; all outputs go to 0 asynchronously.

Optional Feature:
- Macro LMSM_PERF_CNT_EN.
  - Defined: adds output port op_count (16 bits), a saturating count of completed transfers since reset. It holds at 0xFFFF and is cleared only by reset_n.
  - Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package lmsm_pkg holds: OPC_LM, OPC_SM, ADDR_W, NREG, and the state enum {IDLE, ISSUE, DONE}.
- One sub-module, lsb_prio_enc8: combinational lowest-set-bit encoder. Inputs: 8-bit mask. Outputs: 3-bit index and a found flag.

Test Plan:
- LM, mask 8'b1010_0101, base 0x0100, mem_ready=1 → micro-ops R0@0x0100, R2@0x0101, R5@0x0102, R7@0x0103 on consecutive cycles, step_store=0; done the following cycle; stall high from the accept cycle through the last ISSUE cycle.
- SM, mask 8'h00 → no step_valid; done exactly one cycle after accept; stall high only in the accept cycle.
- SM, mask 8'b0000_0110, base 0x0040, mem_ready low for 3 cycles on the first op → R1@0x0040 held stable for 4 cycles, then R2@0x0041; step_store=1.
- LM, mask 8'h03, base 0xFFFF → R0@0xFFFF then R1@0x0000 (wrap).
- LM, mask 8'hFF, kill asserted after the 3rd transfer → IDLE next cycle, exactly 3 transfers, no done; reset_n pulsed mid-sequence → all outputs 0 immediately.
- With LMSM_PERF_CNT_EN: run the two sequences above (mask 8'b1010_0101 then 8'h03) → op_count = 6.

Source files
------------

// File: rtl/lm_sm_sequencer_pkg.sv
// Shared definitions for the LM/SM micro-op sequencer: opcodes, default widths, FSM states.
package lmsm_pkg;

  localparam int ADDR_W = 16;
  localparam int NREG   = 8;

  localparam logic [3:0] OPC_LM = 4'b0110;
  localparam logic [3:0] OPC_SM = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/lm_sm_sequencer_prio_enc.sv
// Combinational lowest-set-bit encoder used to pick the next register of an LM/SM mask.
module lsb_prio_enc8 (
  input  logic [7:0] mask,
  output logic [2:0] index,
  output logic       found
);

  // Scan from the top so the lowest set bit is the last (winning) assignment.
  always_comb begin
    index = 3'd0;
    found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) begin
        index = 3'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: stalls the front end and issues one memory micro-op per set mask bit.
// Optional macro LMSM_PERF_CNT_EN adds a saturating op_count output of completed transfers.
module lm_sm_sequencer
  import lmsm_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int NREG      = 8,
  parameter int ADDR_STEP = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [NREG-1:0]   reg_mask,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              kill,
  input  logic              mem_ready,
  output logic              stall,
  output logic              busy,
  output logic              step_valid,
  output logic              step_store,
  output logic [2:0]        step_reg,
  output logic [ADDR_W-1:0] step_addr,
  output logic              done
`ifdef LMSM_PERF_CNT_EN
  ,
  output logic [15:0]       op_count
`endif
);

  state_t              state, state_nx;
  logic [NREG-1:0]     rem_mask;
  logic [NREG-1:0]     rem_mask_clr;
  logic [ADDR_W-1:0]   addr;
  logic                is_store;
  logic [2:0]          low_idx;
  logic                low_found;
  logic                is_lmsm;
  logic                accept;
  logic                is_issue;
  logic                xfer;

  lsb_prio_enc8 u_enc (
    .mask  (rem_mask),
    .index (low_idx),
    .found (low_found)
  );

  // reset_n gates accept so stall is also forced low while reset is held.
  assign is_lmsm      = (opcode == OPC_LM) || (opcode == OPC_SM);
  assign is_issue     = (state == ISSUE);
  assign accept       = reset_n && (state == IDLE) && start && is_lmsm && !kill;
  assign xfer         = is_issue && low_found && mem_ready;
  assign rem_mask_clr = rem_mask & ~(NREG'(1) << low_idx);

  always_comb begin
    state_nx   = state;
    stall      = accept || is_issue;
    busy       = (state != IDLE);
    step_valid = is_issue && low_found;
    step_store = is_issue && is_store;
    step_reg   = is_issue ? low_idx : 3'd0;
    step_addr  = is_issue ? addr : '0;
    done       = (state == DONE);
    case (state)
      IDLE: begin
        if (accept) state_nx = (reg_mask != '0) ? ISSUE : DONE;
      end
      ISSUE: begin
        if (xfer && (rem_mask_clr == '0)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (kill) state_nx = IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rem_mask <= '0;
      addr     <= '0;
      is_store <= 1'b0;
    end else begin
      state <= state_nx;
      if (kill) begin
        rem_mask <= '0;
      end else if (accept) begin
        rem_mask <= reg_mask;
        addr     <= base_addr;
        is_store <= (opcode == OPC_SM);
      end else if (xfer) begin
        rem_mask <= rem_mask_clr;
        addr     <= addr + ADDR_W'(ADDR_STEP);
      end
    end
  end

`ifdef LMSM_PERF_CNT_EN
  // Transfers that coincide with kill have completed and are counted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_count <= 16'd0;
    end else if (xfer && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule
